if_id_pipe: RTL and testbench

IF/ID pipeline register with stall/flush response for the 5-stage 16-bit pipeline. It sits between the fetch stage, including the instruction cache, and decode. It acts on the flush and hold requests issued by the hazard unit. A one-entry skid buffer catches a fetch that completes in the same cycle a stall is raised, so no instruction is lost or duplicated. It also holds a decoded HALT in place until a flush or reset.

---
 rtl/if_id_pipe_if.sv | 30 +++
 rtl/if_id_pipe.sv | 159 +++++++++++++++
 tb/tb_if_id_pipe.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_pipe_if.sv
// IF/ID pipeline register bundle.
// master: fetch stage and hazard unit (drive fetch and control requests).
// slave : the IF/ID pipeline register itself.
interface if_id_pipe_if;
    // fetch side
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc_inc;
    logic        if_halt;
    logic        if_ready;
    // hazard unit requests
    logic        IF_flush;
    logic        IF_ID_nowrite;
    // decode side
    logic [15:0] id_instr;
    logic [15:0] id_pc_inc;
    logic        id_valid;
    logic        id_halt;
    logic        err;

    modport master (
        output if_valid, if_instr, if_pc_inc, if_halt, IF_flush, IF_ID_nowrite,
        input  if_ready, id_instr, id_pc_inc, id_valid, id_halt, err
    );

    modport slave (
        input  if_valid, if_instr, if_pc_inc, if_halt, IF_flush, IF_ID_nowrite,
        output if_ready, id_instr, id_pc_inc, id_valid, id_halt, err
    );
endinterface

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with flush/hold handling, a one-entry skid buffer
// that catches a fetch accepted in the same cycle a stall is raised, and a
// HALT lock that holds until flush or reset.
// Optional feature: define IF_ID_PERF_EN to add the saturating stall_cycles
// counter port.
module if_id_pipe #(
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic         clk,
    input  logic         rst,
    if_id_pipe_if.slave  bus
`ifdef IF_ID_PERF_EN
    ,
    output logic [15:0]  stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_SKID   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_inc;
        logic        halt;
    } fetch_t;

    state_e      state_q, state_d;
    fetch_t      skid_q, skid_d;
    logic [15:0] id_instr_q, id_instr_d;
    logic [15:0] id_pc_inc_q, id_pc_inc_d;
    logic        id_valid_q, id_valid_d;
    logic        id_halt_q, id_halt_d;
    logic        err_q, err_d;
    // last cycle's fetch inputs, and whether they were presented but refused
    fetch_t      prev_q, prev_d;
    logic        prev_stalled_q, prev_stalled_d;

    fetch_t      fetch;
    logic        ready;
    logic        accept;

    assign fetch  = '{instr: bus.if_instr, pc_inc: bus.if_pc_inc, halt: bus.if_halt};
    // ready decodes registered state only: no path from the hazard requests
    assign ready  = (state_q == ST_NORMAL);
    assign accept = bus.if_valid && ready;

    // Next-state logic: hold beats flush, flush beats advance.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d        = state_q;
        skid_d         = skid_q;
        id_instr_d     = id_instr_q;
        id_pc_inc_d    = id_pc_inc_q;
        id_valid_d     = id_valid_q;
        id_halt_d      = id_halt_q;
        prev_d         = fetch;
        prev_stalled_d = bus.if_valid && !ready;
        err_d          = err_q
                       | (bus.IF_flush && bus.IF_ID_nowrite)
                       | (prev_stalled_q && bus.if_valid && (fetch != prev_q));

        if (bus.IF_ID_nowrite) begin
            // IF/ID frozen; a fetch accepted this cycle is parked in the skid
            if (accept) begin
                skid_d  = fetch;
                state_d = ST_SKID;
            end
        end else if (bus.IF_flush) begin
            // wrong-path instruction: kill IF/ID, skid and any accepted fetch
            id_instr_d  = NOP_INSTR;
            id_pc_inc_d = '0;
            id_valid_d  = 1'b0;
            id_halt_d   = 1'b0;
            skid_d      = '0;
            state_d     = ST_NORMAL;
        end else begin
            unique case (state_q)
                ST_NORMAL: begin
                    if (accept) begin
                        id_instr_d  = fetch.instr;
                        id_pc_inc_d = fetch.pc_inc;
                        id_valid_d  = 1'b1;
                        id_halt_d   = fetch.halt;
                        state_d     = fetch.halt ? ST_HALTED : ST_NORMAL;
                    end else begin
                        // bubble; pc_inc keeps its last value
                        id_instr_d = NOP_INSTR;
                        id_valid_d = 1'b0;
                        id_halt_d  = 1'b0;
                    end
                end
                ST_SKID: begin
                    id_instr_d  = skid_q.instr;
                    id_pc_inc_d = skid_q.pc_inc;
                    id_valid_d  = 1'b1;
                    id_halt_d   = skid_q.halt;
                    skid_d      = '0;
                    state_d     = skid_q.halt ? ST_HALTED : ST_NORMAL;
                end
                default: begin
                    // HALTED: everything holds until flush or reset
                end
            endcase
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_NORMAL;
            // NOTE: the skid entry is reset too, so a reset mid-SKID leaves no stale instruction behind.
            skid_q         <= '0;
            id_instr_q     <= NOP_INSTR;
            id_pc_inc_q    <= '0;
            id_valid_q     <= 1'b0;
            id_halt_q      <= 1'b0;
            err_q          <= 1'b0;
            prev_q         <= '0;
            prev_stalled_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q        <= state_d;
            skid_q         <= skid_d;
            id_instr_q     <= id_instr_d;
            id_pc_inc_q    <= id_pc_inc_d;
            id_valid_q     <= id_valid_d;
            id_halt_q      <= id_halt_d;
            err_q          <= err_d;
            prev_q         <= prev_d;
            prev_stalled_q <= prev_stalled_d;
        end
    end

`ifdef IF_ID_PERF_EN
    logic [15:0] stall_cycles_q;

    // Saturating count of edges with the hold request active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
        end else if (bus.IF_ID_nowrite && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

    assign bus.if_ready  = ready;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc_inc = id_pc_inc_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_halt   = id_halt_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe: directed scenarios followed by random
// fetch/stall/flush traffic compared against a queue-based reference model.
module tb_if_id_pipe;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_inc;
        logic        halt;
    } fetch_t;

    logic clk;
    logic rst;
    if_id_pipe_if bus ();
`ifdef IF_ID_PERF_EN
    logic [15:0] stall_cycles;
`endif

    if_id_pipe #(.NOP_INSTR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_instr, m_pc;
    logic        m_valid, m_halt, m_halted, m_err;
    fetch_t      m_skid[$];
    fetch_t      m_prev;
    logic        m_prev_stalled;
    logic [15:0] m_stall;

    function automatic logic m_ready();
        return (m_skid.size() == 0) && !m_halted;
    endfunction

    task automatic m_reset();
        m_instr = NOP; m_pc = 16'h0; m_valid = 1'b0; m_halt = 1'b0;
        m_halted = 1'b0; m_err = 1'b0; m_skid.delete();
        m_prev = '0; m_prev_stalled = 1'b0; m_stall = 16'h0;
    endtask

    // Apply the current inputs to the model as one clock edge.
    task automatic m_step();
        logic   rdy;
        logic   acc;
        fetch_t f;
        f   = '{instr: bus.if_instr, pc_inc: bus.if_pc_inc, halt: bus.if_halt};
        rdy = m_ready();
        acc = bus.if_valid && rdy;
        if (bus.IF_flush && bus.IF_ID_nowrite) m_err = 1'b1;
        if (m_prev_stalled && bus.if_valid && (f != m_prev)) m_err = 1'b1;
        m_prev_stalled = bus.if_valid && !rdy;
        m_prev = f;
        if (bus.IF_ID_nowrite) begin
            if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (acc) m_skid.push_back(f);
        end else if (bus.IF_flush) begin
            m_instr = NOP; m_pc = 16'h0; m_valid = 1'b0; m_halt = 1'b0;
            m_halted = 1'b0; m_skid.delete();
        end else if (m_halted) begin
            // locked
        end else if (m_skid.size() != 0) begin
            fetch_t s;
            s = m_skid.pop_front();
            m_instr = s.instr; m_pc = s.pc_inc; m_valid = 1'b1; m_halt = s.halt;
            m_halted = s.halt;
        end else if (acc) begin
            m_instr = f.instr; m_pc = f.pc_inc; m_valid = 1'b1; m_halt = f.halt;
            m_halted = f.halt;
        end else begin
            m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".ready"}, 16'(bus.if_ready), 16'(m_ready()));
        check({tag, ".instr"}, bus.id_instr, m_instr);
        check({tag, ".pc"},    bus.id_pc_inc, m_pc);
        check({tag, ".valid"}, 16'(bus.id_valid), 16'(m_valid));
        check({tag, ".halt"},  16'(bus.id_halt), 16'(m_halt));
        check({tag, ".err"},   16'(bus.err), 16'(m_err));
`ifdef IF_ID_PERF_EN
        check({tag, ".stall"}, stall_cycles, m_stall);
`endif
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic h, input logic fl, input logic hd);
        bus.if_valid = v; bus.if_instr = ins; bus.if_pc_inc = pc; bus.if_halt = h;
        bus.IF_flush = fl; bus.IF_ID_nowrite = hd;
    endtask

    task automatic tick(input string tag);
        m_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        m_reset();
        compare_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [15:0] pc_ctr;

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        m_reset();
        #3;
        apply_reset("rst0");
        check("rst0.ready_c", 16'(bus.if_ready), 16'h0001);
        check("rst0.instr_c", bus.id_instr, NOP);

        // single fetch, one-cycle latency
        drive(1'b1, 16'h4123, 16'h0002, 1'b0, 1'b0, 1'b0); tick("t1");
        check("t1.instr_c", bus.id_instr, 16'h4123);
        check("t1.pc_c", bus.id_pc_inc, 16'h0002);
        check("t1.valid_c", 16'(bus.id_valid), 16'h0001);
        check("t1.ready_c", 16'(bus.if_ready), 16'h0001);

        // fetch accepted with a 2-cycle stall goes through the skid
        drive(1'b1, 16'hA105, 16'h0004, 1'b0, 1'b0, 1'b1); tick("t2a");
        check("t2a.instr_c", bus.id_instr, 16'h4123);
        check("t2a.ready_c", 16'(bus.if_ready), 16'h0000);
        drive(1'b1, 16'h1111, 16'h0006, 1'b0, 1'b0, 1'b1); tick("t2b");
        check("t2b.instr_c", bus.id_instr, 16'h4123);
        drive(1'b1, 16'h1111, 16'h0006, 1'b0, 1'b0, 1'b0); tick("t2c");
        check("t2c.instr_c", bus.id_instr, 16'hA105);
        drive(1'b1, 16'h1111, 16'h0006, 1'b0, 1'b0, 1'b0); tick("t2d");
        check("t2d.instr_c", bus.id_instr, 16'h1111);
        check("t2d.ready_c", 16'(bus.if_ready), 16'h0001);

        // flush while in SKID drops the parked entry
        drive(1'b1, 16'h3333, 16'h0008, 1'b0, 1'b0, 1'b1); tick("t3a");
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0); tick("t3b");
        check("t3b.instr_c", bus.id_instr, NOP);
        check("t3b.valid_c", 16'(bus.id_valid), 16'h0000);
        check("t3b.ready_c", 16'(bus.if_ready), 16'h0001);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0); tick("t3c");
        check("t3c.instr_c", bus.id_instr, NOP);

        // HALT lock held for 10 cycles, released by flush
        drive(1'b1, 16'h0000, 16'h000A, 1'b1, 1'b0, 1'b0); tick("t4a");
        check("t4a.halt_c", 16'(bus.id_halt), 16'h0001);
        check("t4a.ready_c", 16'(bus.if_ready), 16'h0000);
        drive(1'b1, 16'h2222, 16'h000C, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick("t4h");
        check("t4h.halt_c", 16'(bus.id_halt), 16'h0001);
        drive(1'b1, 16'h2222, 16'h000C, 1'b0, 1'b1, 1'b0); tick("t4f");
        check("t4f.halt_c", 16'(bus.id_halt), 16'h0000);
        check("t4f.ready_c", 16'(bus.if_ready), 16'h0001);
        drive(1'b1, 16'h2222, 16'h000C, 1'b0, 1'b0, 1'b0); tick("t4g");
        check("t4g.instr_c", bus.id_instr, 16'h2222);

        // reset in the middle of SKID
        drive(1'b1, 16'h4444, 16'h000E, 1'b0, 1'b0, 1'b1); tick("t5a");
        apply_reset("t5r");
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0); tick("t5b");
        check("t5b.instr_c", bus.id_instr, NOP);

`ifdef IF_ID_PERF_EN
        apply_reset("p0");
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick("p5");
        check("p5.count_c", stall_cycles, 16'd5);
        for (int i = 0; i < 65535; i++) begin
            m_step();
            @(posedge clk);
        end
        #1;
        compare_all("psat");
        check("psat.count_c", stall_cycles, 16'hFFFF);
        apply_reset("p1");
`endif

        // random traffic from a well-behaved fetch stage
        pc_ctr = 16'h0100;
        for (int n = 0; n < 600; n++) begin
            int r;
            if (!m_prev_stalled) begin
                bus.if_valid  = ($urandom_range(0, 3) != 0);
                bus.if_instr  = 16'($urandom);
                bus.if_pc_inc = pc_ctr;
                bus.if_halt   = ($urandom_range(0, 24) == 0);
                pc_ctr        = pc_ctr + 16'd2;
            end
            r = $urandom_range(0, 15);
            bus.IF_flush      = (r < 2);
            bus.IF_ID_nowrite = (r >= 2) && (r < 6);
            tick("rnd");
        end

        // simultaneous flush and hold: hold wins, err is sticky
        apply_reset("e0");
        drive(1'b1, 16'h9ABC, 16'h0020, 1'b0, 1'b0, 1'b0); tick("e1");
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1); tick("e2");
        check("e2.err_c", 16'(bus.err), 16'h0001);
        check("e2.instr_c", bus.id_instr, 16'h9ABC);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick("e3");
        check("e3.err_c", 16'(bus.err), 16'h0001);
        apply_reset("e4");
        check("e4.err_c", 16'(bus.err), 16'h0000);

        // fetch changes its inputs while refused
        drive(1'b1, 16'h6666, 16'h0012, 1'b0, 1'b0, 1'b1); tick("e5");
        drive(1'b1, 16'h7777, 16'h0014, 1'b0, 1'b0, 1'b1); tick("e6");
        check("e6.err_c", 16'(bus.err), 16'h0000);
        drive(1'b1, 16'h7778, 16'h0014, 1'b0, 1'b0, 1'b1); tick("e7");
        check("e7.err_c", 16'(bus.err), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
